// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with a byte/halfword/word store controller (read-modify-write FSM).
// Optional alignment checking is enabled by defining DATA_MEM_ALIGN_CHECK_EN.
module data_mem_ctrl #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [31:0]          address,
  input  logic [1:0]           write,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    LATCH = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t                 state;
  logic [AW-1:0]          addr_q;
  logic [1:0]             write_q;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic [WORD_SIZE-1:0]   mem [DEPTH];
  logic [WORD_SIZE-1:0]   mem_rd_p1;
  logic [ADDR_WIDTH-1:0]  idx;
  logic                   unused_addr_hi;

  // Upper byte-address bits wrap silently and are never looked at.
  assign unused_addr_hi = ^address[31:AW];
  assign idx            = addr_q[AW-1:2];

`ifdef DATA_MEM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] lo, input logic [1:0] kind);
    return ((kind == 2'b10) && lo[0]) || ((kind == 2'b11) && (lo != 2'b00));
  endfunction
`else
  function automatic logic [AW-1:0] align_addr(input logic [AW-1:0] a, input logic [1:0] kind);
    logic [AW-1:0] r;
    r = a;
    if (kind == 2'b10)      r[0]   = 1'b0;
    else if (kind == 2'b11) r[1:0] = 2'b00;
    return r;
  endfunction
`endif

  function automatic logic [WORD_SIZE-1:0] merge_word(
    input logic [WORD_SIZE-1:0] old,
    input logic [WORD_SIZE-1:0] wd,
    input logic [1:0]           kind,
    input logic [1:0]           lo
  );
    logic [WORD_SIZE-1:0] m;
    m = old;
    case (kind)
      2'b01:   m[{lo, 3'b000} +: 8]     = wd[7:0];
      2'b10:   m[{lo[1], 4'b0000} +: 16] = wd[15:0];
      2'b11:   m = wd;
      default: m = old;
    endcase
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      addr_q  <= '0;
      write_q <= '0;
      wdata_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            write_q <= write;
            wdata_q <= wdata;
            error   <= 1'b0;
            busy    <= 1'b1;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            addr_q  <= address[AW-1:0];
            if (misaligned(address[1:0], write)) begin
              state <= ERR;
              error <= 1'b1;
              done  <= 1'b1;
            end else begin
              state <= RD;
            end
`else
            addr_q  <= align_addr(address[AW-1:0], write);
            state   <= RD;
`endif
          end
        end
        RD:    state <= LATCH;
        LATCH: begin
          rdata <= mem_rd_p1;
          if (write_q == 2'b00) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= WR;
          end
        end
        WR: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          error <= 1'b1;
        end
      endcase
    end
  end

  // Storage is never reset; a write only lands if the FSM is still in WR at the edge.
  always_ff @(posedge clk) begin
    if (state == RD) mem_rd_p1 <= mem[idx];
    if (state == WR) mem[idx] <= merge_word(rdata, wdata_q, write_q, addr_q[1:0]);
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word-index width; storage depth is 2^ADDR_WIDTH words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port req, input, 1, request strobe; sampled only in IDLE.
REQ-006 SHALL have port address, input, 32, byte address of the access.
REQ-007 SHALL have port write, input, 2, access kind: 00 read, 01 byte store, 10 halfword store, 11 word store.
REQ-008 SHALL have port wdata, input, WORD_SIZE, store data, right-justified (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port rdata, output, WORD_SIZE, registered full aligned word containing the address.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port error, output, 1, alignment error flag, sticky until the next accepted req.

Function
REQ-013 SHALL implement states IDLE, RD, LATCH, WR, DONE, ERR.
REQ-014 SHALL, in IDLE with req=1, latch address, write and wdata, clear error, and go to RD (or ERR per REQ-021).
REQ-015 SHALL ignore req in every state other than IDLE; latched request fields SHALL NOT change until the next IDLE acceptance.
REQ-016 SHALL, in RD, issue a synchronous read of word index address[ADDR_WIDTH+1:2]; go to LATCH.
REQ-017 SHALL, in LATCH, load rdata with the read word; go to DONE if write=00, else to WR.
REQ-018 SHALL, in WR, write the merged word: only the addressed lane(s) replaced (byte lane address[1:0]; half lanes selected by address[1]; word replaces all); go to DONE.
REQ-019 SHALL, in DONE and ERR, assert done for exactly that cycle and return to IDLE.
REQ-020 SHALL give latency, req-accept edge = cycle 0: read done in cycle 3, store done in cycle 4; rdata valid from cycle 3 and held until the next LATCH.
REQ-021 SHALL treat halfword access with address[0]=1 and word access with address[1:0]!=0 as misaligned: go to ERR, set error, leave storage and rdata unchanged.
REQ-022 SHALL wrap address bits above ADDR_WIDTH+1 silently (no error for out-of-range addresses).
REQ-023 SHALL accept a new req in the IDLE cycle immediately following DONE or ERR (back-to-back throughput: one access per 4 or 5 cycles).
REQ-024 SHALL enter FSM default state handling by returning to IDLE with error set for any illegal state encoding.

Reset
REQ-025 SHALL, on rst low, immediately force state IDLE, rdata=0, busy=0, done=0, error=0, latched fields=0.
REQ-026 SHALL abort any in-flight request on reset; storage written only if the WR edge completed before reset asserted.
REQ-027 SHALL NOT clear storage contents on reset.

Configuration
REQ-028 SHALL, with macro DATA_MEM_ALIGN_CHECK_EN defined, perform the misalignment check of REQ-021.
REQ-029 SHALL, without DATA_MEM_ALIGN_CHECK_EN, never enter ERR for alignment: halfword accesses force address[0]=0, word accesses force address[1:0]=0, error stays 0 except for REQ-024.

Verification
REQ-030 SHALL cover: word store 0xDEADBEEF @0x10, then read @0x10 -> done in cycle 4 then cycle 3, rdata=0xDEADBEEF.
REQ-031 SHALL cover: word 0x11223344 @0x20, byte store 0xAA @0x21, read @0x20 -> rdata=0x1122AA44.
REQ-032 SHALL cover: halfword store 0xBEEF @0x22 over 0x11223344 -> read @0x20 gives 0xBEEF3344.
REQ-033 SHALL cover: with DATA_MEM_ALIGN_CHECK_EN, word store @0x13 -> ERR, done and error high in cycle 1, word @0x10 unchanged; next valid req clears error.
REQ-034 SHALL cover: rst low during WR-bound store at cycle 2 -> outputs 0 immediately, target word unchanged on subsequent read.
REQ-035 SHALL cover: req held high through a whole read -> exactly one done pulse per accepted request, second access starts only in IDLE.
